// File: rtl/amm_wr_master.sv
// Avalon-MM write master: buffers stream words in a small FIFO and writes them to
// consecutive word addresses, holding the request stable while waitrequest is high.
module amm_wr_master #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_CNT   = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] length_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [BYTE_CNT-1:0]   byteen_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [ADDR_WIDTH-1:0] amm_address_o,
    output logic                  amm_write_o,
    output logic [DATA_WIDTH-1:0] amm_writedata_o,
    output logic [BYTE_CNT-1:0]   amm_byteenable_o,
    input  logic                  amm_waitrequest_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [BYTE_CNT-1:0]   fifo_be   [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           fifo_cnt;
    logic [CW-1:0]         len_q, in_cnt, out_cnt;
    logic                  fifo_empty, fifo_full;
    logic                  push, store, pop, load, accept, last;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH_C);
    assign ready_o    = (state == S_WRITE) && !fifo_full && (in_cnt < len_q);
    assign push       = valid_i && ready_o;
    assign accept     = amm_write_o && !amm_waitrequest_i;
    assign last       = accept && ((out_cnt + CW'(1)) == len_q);
    // Output slot refills when idle or being accepted; an empty FIFO bypasses
    // the incoming beat straight into the output register.
    assign load       = (!amm_write_o || !amm_waitrequest_i) && (!fifo_empty || push);
    assign pop        = load && !fifo_empty;
    assign store      = push && !(fifo_empty && load);

    assign busy_o = (state != S_IDLE);
    assign done_o = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (run_i) state_nxt = (length_i != '0) ? S_WRITE : S_DONE;
            S_WRITE: if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            len_q         <= '0;
            in_cnt        <= '0;
            out_cnt       <= '0;
            amm_address_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && run_i) begin
                len_q         <= {1'b0, length_i};
                in_cnt        <= '0;
                out_cnt       <= '0;
                amm_address_o <= base_addr_i;
            end else begin
                if (push) in_cnt <= in_cnt + CW'(1);
                if (accept) begin
                    out_cnt       <= out_cnt + CW'(1);
                    amm_address_o <= amm_address_o + ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({store, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            fifo_data[wr_ptr] <= data_i;
            fifo_be[wr_ptr]   <= byteen_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amm_write_o      <= 1'b0;
            amm_writedata_o  <= '0;
            amm_byteenable_o <= '0;
        end else if (load) begin
            amm_write_o      <= 1'b1;
            amm_writedata_o  <= fifo_empty ? data_i   : fifo_data[rd_ptr];
            amm_byteenable_o <= fifo_empty ? byteen_i : fifo_be[rd_ptr];
        end else if (accept) begin
            amm_write_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_amm_wr_master.sv
// Bench for amm_wr_master: random stream/waitrequest stimulus scored against a
// queue model of expected writes (addr = base + beat index, data/be as accepted).
module tb_amm_wr_master;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int BC = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run_i;
    logic [AW-1:0] base_addr_i, length_i;
    logic          busy_o, done_o;
    logic [DW-1:0] data_i;
    logic [BC-1:0] byteen_i;
    logic          valid_i, ready_o;
    logic [AW-1:0] amm_address_o;
    logic          amm_write_o;
    logic [DW-1:0] amm_writedata_o;
    logic [BC-1:0] amm_byteenable_o;
    logic          amm_waitrequest_i;

    amm_wr_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_CNT(BC), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .run_i(run_i), .base_addr_i(base_addr_i),
        .length_i(length_i), .busy_o(busy_o), .done_o(done_o), .data_i(data_i),
        .byteen_i(byteen_i), .valid_i(valid_i), .ready_o(ready_o),
        .amm_address_o(amm_address_o), .amm_write_o(amm_write_o),
        .amm_writedata_o(amm_writedata_o), .amm_byteenable_o(amm_byteenable_o),
        .amm_waitrequest_i(amm_waitrequest_i)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BC-1:0] b;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           prev_w;
    int            cyc = 0;
    bit            hs_q, prev_hold, m_busy, first_wr;
    logic [AW-1:0] m_base, m_len;
    int            in_seen, wr_seen, done_cnt, last_cyc, first_hs, run_cyc, done_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: sampled mid-cycle, predicts what the next edge commits.
    always @(negedge clk) begin
        bit  e_done, run_acc;
        wr_t w;
        if (!rst_n) begin
            exp_q.delete();
            m_busy = 0; hs_q = 0; prev_hold = 0; first_wr = 0;
            in_seen = 0; wr_seen = 0;
        end else begin
            e_done = m_busy && (wr_seen == int'(m_len)) && (last_cyc + 1 == cyc);
            chk("busy", busy_o, m_busy);
            chk("done", done_o, e_done);
            run_acc = run_i && !m_busy;
            if (e_done) begin
                m_busy = 0; done_cnt++; done_cyc = cyc;
            end
            if (run_acc) begin
                m_busy = 1; m_base = base_addr_i; m_len = length_i;
                in_seen = 0; wr_seen = 0; last_cyc = cyc; run_cyc = cyc;
                first_hs = -1; first_wr = 1;
            end
            if (prev_hold) begin
                chk("hold_wr", amm_write_o, 1'b1);
                chk("hold_addr", amm_address_o, prev_w.a);
                chk("hold_data", amm_writedata_o, prev_w.d);
                chk("hold_be", amm_byteenable_o, prev_w.b);
            end
            prev_hold = amm_write_o && amm_waitrequest_i;
            prev_w = '{a: amm_address_o, d: amm_writedata_o, b: amm_byteenable_o};
            if (amm_write_o) begin
                if (first_wr) begin
                    chk("latency", cyc, first_hs + 1);
                    first_wr = 0;
                end
                if (exp_q.size() == 0) chk("spur_wr", amm_write_o, 1'b0);
                else if (!amm_waitrequest_i) begin
                    w = exp_q.pop_front();
                    chk("wr_addr", amm_address_o, w.a);
                    chk("wr_data", amm_writedata_o, w.d);
                    chk("wr_be", amm_byteenable_o, w.b);
                    wr_seen++; last_cyc = cyc;
                end
            end
            if (!m_busy || in_seen >= int'(m_len)) chk("rdy_off", ready_o, 1'b0);
            hs_q = valid_i && ready_o;
            if (hs_q) begin
                if (first_hs < 0) first_hs = cyc;
                exp_q.push_back('{a: m_base + AW'(in_seen), d: data_i, b: byteen_i});
                in_seen++;
            end
        end
    end

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_wr"}, amm_write_o, 1'b0);
        chk({tag, "_addr"}, amm_address_o, '0);
        chk({tag, "_data"}, amm_writedata_o, '0);
        chk({tag, "_be"}, amm_byteenable_o, '0);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_rdy"}, ready_o, 1'b0);
    endtask

    // wmode: 0 no wait, 1 random wait, 2 wait 3 clks on the 2nd write
    task automatic xfer(input logic [AW-1:0] base, input logic [AW-1:0] len, input int beats,
                        input int wmode, input bit gaps, input int mid_run,
                        input int be0_beat, input int abort_wr);
        int beat = 0, wctr = 0, start;
        bit finished = 0, aborted = 0;
        start = done_cnt;
        @(posedge clk); #1;
        run_i = 1; base_addr_i = base; length_i = len; valid_i = 0;
        for (int t = 0; t < 600; t++) begin
            @(posedge clk); #1;
            run_i = (mid_run != 0) && (t == mid_run);
            if (run_i) begin base_addr_i = ~base; length_i = len + AW'(5); end
            if (done_cnt != start) begin finished = 1; break; end
            if (abort_wr > 0 && wr_seen == abort_wr) begin
                #2 rst_n = 1'b0;
                #1 chk_idle_outs("abort");
                aborted = 1;
                break;
            end
            if (valid_i && hs_q) beat++;
            if (!(valid_i && !hs_q)) begin
                if (beat < beats && (!gaps || $urandom_range(0, 3) != 0)) begin
                    valid_i  = 1'b1;
                    data_i   = {$urandom, $urandom};
                    byteen_i = (beat == be0_beat) ? '0 : BC'($urandom);
                end else valid_i = 1'b0;
            end
            case (wmode)
                1:       amm_waitrequest_i = ($urandom_range(0, 99) < 30);
                2: begin
                    amm_waitrequest_i = (wr_seen == 1) && (wctr < 3);
                    if (amm_waitrequest_i) wctr++;
                end
                default: amm_waitrequest_i = 1'b0;
            endcase
        end
        valid_i = 0; run_i = 0; amm_waitrequest_i = 0;
        if (aborted) begin
            repeat (3) @(posedge clk);
            #1 chk("abort_nodone", done_cnt - start, 0);
            chk_idle_outs("in_rst");
            rst_n = 1'b1;
        end else begin
            if (!finished) chk("timeout", finished, 1'b1);
            repeat (2) @(posedge clk); #1;
            chk("n_in", in_seen, len);
            chk("n_wr", wr_seen, len);
            chk("q_empty", exp_q.size(), 0);
            chk("n_done", done_cnt - start, 1);
            chk("busy_end", busy_o, 1'b0);
        end
    endtask

    initial begin
        rst_n = 0; run_i = 0; base_addr_i = '0; length_i = '0;
        data_i = '0; byteen_i = '0; valid_i = 0; amm_waitrequest_i = 0;
        done_cnt = 0; run_cyc = 0; done_cyc = 0;
        repeat (3) @(posedge clk);
        #1 chk_idle_outs("reset");
        rst_n = 1;

        xfer(10'h010, 4, 4, 0, 0, 0, -1, 0);
        chk("b2b_span", done_cyc - run_cyc, 6);
        xfer(10'h080, 3, 3, 2, 0, 0, -1, 0);
        xfer(10'h3FE, 4, 4, 0, 0, 0, -1, 0);
        xfer(10'h055, 0, 2, 0, 0, 0, -1, 0);
        xfer(10'h100, 2, 5, 0, 0, 1, 1, 0);
        xfer(10'h200, 4, 4, 0, 0, 0, -1, 1);
        xfer(10'h2A0, 4, 4, 0, 0, 0, -1, 0);
        for (int i = 0; i < 6; i++)
            xfer(AW'($urandom), AW'($urandom_range(1, 12)), 16, 1, 1, 0, -1, 0);
        xfer(10'h3FC, 10, 10, 1, 1, 0, 3, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

endmodule
